// File: rtl/painterengine_gpu_dvi_scanout_if.sv
// Framebuffer read port shared by the scanout engine and the memory it reads.
//
// Signals (named from the scanout engine's point of view):
//   o_wire_mem_req   registered read request, held until the acknowledge cycle
//   o_wire_mem_addr  byte address of the requested pixel, stable while requesting
//   i_wire_mem_ack   one-cycle acknowledge; data is valid in this cycle
//   i_wire_mem_data  pixel word returned with the acknowledge
//
// Modports: master = scanout engine, slave = memory / bus bridge.
interface painterengine_gpu_dvi_scanout_if;
    logic        o_wire_mem_req;
    logic [31:0] o_wire_mem_addr;
    logic        i_wire_mem_ack;
    logic [31:0] i_wire_mem_data;

    modport master (
        output o_wire_mem_req,
        output o_wire_mem_addr,
        input  i_wire_mem_ack,
        input  i_wire_mem_data
    );

    modport slave (
        input  o_wire_mem_req,
        input  o_wire_mem_addr,
        output i_wire_mem_ack,
        output i_wire_mem_data
    );
endinterface

// File: rtl/painterengine_gpu_dvi_scanout.sv
// Framebuffer scanout engine: fetches width*height pixels from a linear framebuffer through a
// single-outstanding read port into a show-ahead prefetch FIFO and hands them to a DVI timing
// generator one per i_wire_next_rgb pulse. The generator is held in reset until the FIFO has
// been prefilled (full, or the whole frame fetched).
//
// Ports:
//   i_wire_pixel_clock, i_wire_resetn   clock, asynchronous active-low reset
//   i_wire_start                        frame start pulse (accepted only when idle)
//   i_wire_base_addr                    framebuffer base byte address
//   i_wire_clip_width/height            frame size in pixels, sampled on accepted start
//   mem_io                              framebuffer read port (master side)
//   o_wire_dvi_resetn                   active-low reset to the timing generator
//   i_wire_next_rgb                     generator consumed the current pixel
//   o_wire_rgba                         head of the prefetch FIFO, 0 when empty
//   i_wire_dvi_done                     generator finished the frame
//   o_wire_busy, o_wire_done            frame in progress / one-cycle completion pulse
//   o_wire_underflow                    sticky: a pixel was consumed while the FIFO was empty
//   o_wire_underflow_cnt                number of such events (saturating)
//
// Build option: define PAINTERENGINE_GPU_DVI_SCANOUT_UNDERFLOW_CNT_EN to implement the
// underflow event counter; otherwise o_wire_underflow_cnt is tied to zero.
module painterengine_gpu_dvi_scanout #(
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned PIXEL_BYTES = 4
) (
    input  logic        i_wire_pixel_clock,
    input  logic        i_wire_resetn,
    input  logic        i_wire_start,
    input  logic [31:0] i_wire_base_addr,
    input  logic [15:0] i_wire_clip_width,
    input  logic [15:0] i_wire_clip_height,
    painterengine_gpu_dvi_scanout_if.master mem_io,
    output logic        o_wire_dvi_resetn,
    input  logic        i_wire_next_rgb,
    output logic [31:0] o_wire_rgba,
    input  logic        i_wire_dvi_done,
    output logic        o_wire_busy,
    output logic        o_wire_done,
    output logic        o_wire_underflow,
    output logic [15:0] o_wire_underflow_cnt
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {StIdle, StPrefill, StStream, StDone} state_e;

    state_e        state_q, state_d;
    logic [31:0]   base_q, base_d;
    logic [31:0]   total_q, total_d;
    logic [31:0]   fetched_q, fetched_d;
    logic          req_q, req_d;
    logic [31:0]   addr_q, addr_d;
    logic          stale_q, stale_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          underflow_q, underflow_d;
    logic [31:0]   fifo_mem [FIFO_DEPTH];

    logic        start_acc;
    logic        active;
    logic        fifo_empty;
    logic        fifo_full;
    logic        ack_acc;
    logic        push;
    logic        pop;
    logic        underrun;
    logic        issue;
    logic        flush;
    logic [31:0] frame_total;

    // Datapath control decode
    always_comb begin
        start_acc   = (state_q == StIdle) && i_wire_start;
        active      = (state_q == StPrefill) || (state_q == StStream);
        fifo_empty  = (count_q == '0);
        fifo_full   = (count_q == CW'(FIFO_DEPTH));
        ack_acc     = req_q && mem_io.i_wire_mem_ack;
        // An ack for a request left over from an earlier frame is dropped.
        push        = ack_acc && active && !stale_q;
        pop         = (state_q == StStream) && i_wire_next_rgb && !fifo_empty;
        underrun    = (state_q == StStream) && i_wire_next_rgb && fifo_empty;
        // The outstanding request already owns a FIFO slot.
        issue       = active && !req_q && (fetched_q < total_q) &&
                      ((count_q + CW'(req_q)) < CW'(FIFO_DEPTH));
        flush       = (state_q == StIdle) || (state_q == StDone);
        frame_total = {16'h0, i_wire_clip_width} * {16'h0, i_wire_clip_height};
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (i_wire_start) begin
                    state_d = (frame_total == 32'h0) ? StDone : StPrefill;
                end
            end
            StPrefill: begin
                if (fifo_full || (fetched_q == total_q)) state_d = StStream;
            end
            StStream: begin
                if (i_wire_dvi_done) state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // FSM: state-decoded outputs and FIFO head
    always_comb begin
        o_wire_dvi_resetn = (state_q == StStream);
        o_wire_busy       = (state_q == StPrefill) || (state_q == StStream);
        o_wire_done       = (state_q == StDone);
        o_wire_underflow  = underflow_q;
        o_wire_rgba       = fifo_empty ? 32'h0 : fifo_mem[rd_ptr_q];
    end

    assign mem_io.o_wire_mem_req  = req_q;
    assign mem_io.o_wire_mem_addr = addr_q;

    // Frame parameters, fetch sequencing and FIFO bookkeeping
    always_comb begin
        base_d      = base_q;
        total_d     = total_q;
        fetched_d   = fetched_q;
        req_d       = req_q;
        addr_d      = addr_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        underflow_d = underflow_q;
        // Remember that the pending request belongs to a finished frame.
        stale_d     = req_q && !ack_acc && (stale_q || !active);

        if (start_acc) begin
            base_d      = i_wire_base_addr;
            total_d     = frame_total;
            underflow_d = 1'b0;
        end else if (underrun) begin
            underflow_d = 1'b1;
        end

        if (ack_acc) begin
            req_d = 1'b0;
        end else if (issue) begin
            req_d  = 1'b1;
            addr_d = base_q + fetched_q * 32'(PIXEL_BYTES);
        end

        if (flush) begin
            fetched_d = '0;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
        end else begin
            if (push) begin
                fetched_d = fetched_q + 32'd1;
                wr_ptr_d  = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // FSM: state register and datapath flops
    always_ff @(posedge i_wire_pixel_clock or negedge i_wire_resetn) begin
        if (!i_wire_resetn) begin
            state_q     <= StIdle;
            base_q      <= '0;
            total_q     <= '0;
            fetched_q   <= '0;
            req_q       <= 1'b0;
            addr_q      <= '0;
            stale_q     <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            total_q     <= total_d;
            fetched_q   <= fetched_d;
            req_q       <= req_d;
            addr_q      <= addr_d;
            stale_q     <= stale_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            underflow_q <= underflow_d;
        end
    end

    // FIFO storage needs no reset; entries are only read while counted valid.
    always_ff @(posedge i_wire_pixel_clock) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= mem_io.i_wire_mem_data;
        end
    end

`ifdef PAINTERENGINE_GPU_DVI_SCANOUT_UNDERFLOW_CNT_EN
    logic [15:0] underflow_cnt_q, underflow_cnt_d;

    always_comb begin
        underflow_cnt_d = underflow_cnt_q;
        if (start_acc) begin
            underflow_cnt_d = '0;
        end else if (underrun && (underflow_cnt_q != 16'hFFFF)) begin
            underflow_cnt_d = underflow_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge i_wire_pixel_clock or negedge i_wire_resetn) begin
        if (!i_wire_resetn) begin
            underflow_cnt_q <= '0;
        end else begin
            underflow_cnt_q <= underflow_cnt_d;
        end
    end

    assign o_wire_underflow_cnt = underflow_cnt_q;
`else
    assign o_wire_underflow_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_painterengine_gpu_dvi_scanout.sv
// Scoreboard bench for painterengine_gpu_dvi_scanout: each started frame pushes its expected
// request addresses and pixel words; a monitor compares them against the read port and the
// pixels handed to the (modelled) DVI generator. A memory model and a paced consumer drive
// the read port and i_wire_next_rgb.
module tb_painterengine_gpu_dvi_scanout;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned PB    = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic [15:0] clip_w = '0;
    logic [15:0] clip_h = '0;
    logic        next_rgb = 1'b0;
    logic        dvi_done = 1'b0;
    logic        dvi_resetn, busy, done, underflow;
    logic [31:0] rgba;
    logic [15:0] underflow_cnt;

    painterengine_gpu_dvi_scanout_if mem_bus ();

    painterengine_gpu_dvi_scanout #(
        .FIFO_DEPTH (DEPTH),
        .PIXEL_BYTES(PB)
    ) u_dut (
        .i_wire_pixel_clock  (clk),
        .i_wire_resetn       (rstn),
        .i_wire_start        (start),
        .i_wire_base_addr    (base_addr),
        .i_wire_clip_width   (clip_w),
        .i_wire_clip_height  (clip_h),
        .mem_io              (mem_bus),
        .o_wire_dvi_resetn   (dvi_resetn),
        .i_wire_next_rgb     (next_rgb),
        .o_wire_rgba         (rgba),
        .i_wire_dvi_done     (dvi_done),
        .o_wire_busy         (busy),
        .o_wire_done         (done),
        .o_wire_underflow    (underflow),
        .o_wire_underflow_cnt(underflow_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pix_of(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Scoreboard state
    logic [31:0] exp_addr[$];
    logic [31:0] exp_pix[$];
    int          occ = 0;
    int          acks = 0;
    int          delivered = 0;
    int          uf_seen = 0;
    int          cons_target = 0;

    // Memory model controls
    bit          mem_en = 1'b1;
    int          lat = 1;
    logic        force_ack = 1'b0;
    logic [31:0] force_data = '0;
    int          cons_gap = 1;

    initial begin
        int wait_cnt;
        wait_cnt = 0;
        mem_bus.i_wire_mem_ack  = 1'b0;
        mem_bus.i_wire_mem_data = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!mem_en) begin
                wait_cnt                = 0;
                mem_bus.i_wire_mem_ack  = force_ack;
                mem_bus.i_wire_mem_data = force_data;
            end else if (!rstn) begin
                wait_cnt               = 0;
                mem_bus.i_wire_mem_ack = 1'b0;
            end else if (mem_bus.i_wire_mem_ack) begin
                mem_bus.i_wire_mem_ack = 1'b0;
            end else if (mem_bus.o_wire_mem_req) begin
                if (wait_cnt >= lat) begin
                    mem_bus.i_wire_mem_ack  = 1'b1;
                    mem_bus.i_wire_mem_data = pix_of(mem_bus.o_wire_mem_addr);
                    wait_cnt                = 0;
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    // Consumer: one pop every cons_gap cycles while streaming and pixels remain
    initial begin
        int gap_cnt;
        gap_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rstn && dvi_resetn && (delivered < cons_target)) begin
                if (gap_cnt == 0) begin
                    next_rgb = 1'b1;
                    gap_cnt  = cons_gap - 1;
                end else begin
                    next_rgb = 1'b0;
                    gap_cnt--;
                end
            end else begin
                next_rgb = 1'b0;
                gap_cnt  = 0;
            end
        end
    end

    // Monitor: everything seen here takes effect at the following rising edge
    initial begin
        bit          prev_wait;
        logic [31:0] prev_addr;
        prev_wait = 1'b0;
        prev_addr = '0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                prev_wait = 1'b0;
            end else begin
                if (prev_wait && mem_bus.o_wire_mem_req) begin
                    check32("addr_stable", mem_bus.o_wire_mem_addr, prev_addr);
                end
                prev_wait = mem_bus.o_wire_mem_req && !mem_bus.i_wire_mem_ack;
                prev_addr = mem_bus.o_wire_mem_addr;
                if (occ == DEPTH) check1("no_req_when_full", mem_bus.o_wire_mem_req, 1'b0);
                if (busy && occ == 0) check32("rgba_empty", rgba, 32'h0);
                if (next_rgb && dvi_resetn) begin
                    if (occ > 0) begin
                        check1("pix_expected", exp_pix.size() != 0, 1'b1);
                        if (exp_pix.size() != 0) check32("pix_data", rgba, exp_pix.pop_front());
                        occ--;
                        delivered++;
                    end else begin
                        uf_seen++;
                    end
                end
                if (mem_bus.o_wire_mem_req && mem_bus.i_wire_mem_ack) begin
                    check1("req_expected", exp_addr.size() != 0, 1'b1);
                    if (exp_addr.size() != 0) begin
                        check32("req_addr", mem_bus.o_wire_mem_addr, exp_addr.pop_front());
                    end
                    occ++;
                    acks++;
                end
            end
        end
    end

    task automatic start_frame(input logic [31:0] b, input logic [15:0] w, input logic [15:0] h);
        logic [31:0] total;
        logic [31:0] a;
        total = 32'(w) * 32'(h);
        for (int n = 0; n < int'(total); n++) begin
            a = b + 32'(n) * PB;
            exp_addr.push_back(a);
            exp_pix.push_back(pix_of(a));
        end
        delivered   = 0;
        acks        = 0;
        uf_seen     = 0;
        cons_target = int'(total);
        start       = 1'b1;
        base_addr   = b;
        clip_w      = w;
        clip_h      = h;
        tick();
        start = 1'b0;
        check1("start_busy", busy, total != 0);
        check1("start_clears_underflow", underflow, 1'b0);
        check32("start_clears_uf_cnt", 32'(underflow_cnt), 32'h0);
    endtask

    task automatic wait_stream(input int exp_acks);
        int i;
        for (i = 0; i < 5000 && !dvi_resetn; i++) tick();
        check1("stream_reached", dvi_resetn, 1'b1);
        check32("prefill_acks", 32'(acks), 32'(exp_acks));
    endtask

    task automatic end_frame();
        int i;
        for (i = 0; i < 5000 && delivered < cons_target; i++) tick();
        check32("delivered", 32'(delivered), 32'(cons_target));
        check1("done_before_dvi_done", done, 1'b0);
        dvi_done = 1'b1;
        tick();
        dvi_done = 1'b0;
        check1("done_pulse", done, 1'b1);
        check1("done_busy_low", busy, 1'b0);
        check1("done_dvi_resetn_low", dvi_resetn, 1'b0);
        tick();
        check1("done_one_cycle", done, 1'b0);
        check1("idle_busy", busy, 1'b0);
        check32("addr_queue_empty", 32'(exp_addr.size()), 32'h0);
        check32("pix_queue_empty", 32'(exp_pix.size()), 32'h0);
    endtask

    initial begin
        int exp_uf;
        repeat (3) tick();
        // Reset state
        check1("rst_req", mem_bus.o_wire_mem_req, 1'b0);
        check32("rst_addr", mem_bus.o_wire_mem_addr, 32'h0);
        check1("rst_dvi_resetn", dvi_resetn, 1'b0);
        check1("rst_busy", busy, 1'b0);
        check1("rst_done", done, 1'b0);
        check1("rst_underflow", underflow, 1'b0);
        check32("rst_uf_cnt", 32'(underflow_cnt), 32'h0);
        check32("rst_rgba", rgba, 32'h0);
        rstn = 1'b1;
        tick();

        // 4x2 frame, fully prefetched before the generator is released
        lat = 1;
        cons_gap = 1;
        start_frame(32'h0000_1000, 16'd4, 16'd2);
        wait_stream(8);
        end_frame();
        check1("t1_no_underflow", underflow, 1'b0);

        // 64x1 frame: prefill stops at a full FIFO
        cons_gap = 4;
        start_frame(32'h0004_0000, 16'd64, 16'd1);
        wait_stream(DEPTH);
        end_frame();
        check1("t2_no_underflow", underflow, 1'b0);

        // Slow memory with an eager consumer underflows
        lat = 20;
        cons_gap = 1;
        start_frame(32'h0000_8000, 16'd32, 16'd1);
        wait_stream(DEPTH);
        end_frame();
        check1("t3_underflow", underflow, 1'b1);
        exp_uf = (uf_seen > 65535) ? 65535 : uf_seen;
`ifdef PAINTERENGINE_GPU_DVI_SCANOUT_UNDERFLOW_CNT_EN
        check32("t3_uf_cnt", 32'(underflow_cnt), 32'(exp_uf));
`else
        check32("t3_uf_cnt_tied", 32'(underflow_cnt), 32'h0);
`endif

        // Start while streaming is ignored; original base/size complete the frame
        lat = 1;
        cons_gap = 4;
        start_frame(32'h0000_2000, 16'd32, 16'd1);
        wait_stream(DEPTH);
        start     = 1'b1;
        base_addr = 32'h0000_9000;
        clip_w    = 16'd2;
        clip_h    = 16'd2;
        tick();
        start = 1'b0;
        check1("t4_still_streaming", dvi_resetn, 1'b1);
        end_frame();

        // Zero-size frame: straight to DONE, no fetch
        start_frame(32'h0000_4000, 16'd0, 16'd5);
        check1("t5_done", done, 1'b1);
        check1("t5_no_req", mem_bus.o_wire_mem_req, 1'b0);
        tick();
        check1("t5_done_low", done, 1'b0);
        check1("t5_busy_low", busy, 1'b0);
        check1("t5_no_req_after", mem_bus.o_wire_mem_req, 1'b0);

        // Reset mid-stream with a request pending
        lat = 6;
        cons_gap = 4;
        start_frame(32'h0000_3000, 16'd64, 16'd1);
        wait_stream(DEPTH);
        for (int i = 0; i < 200 && !(mem_bus.o_wire_mem_req && !mem_bus.i_wire_mem_ack); i++) begin
            tick();
        end
        check1("t6_req_pending", mem_bus.o_wire_mem_req, 1'b1);
        mem_en = 1'b0;
        rstn   = 1'b0;
        #1;
        check1("t6_req", mem_bus.o_wire_mem_req, 1'b0);
        check32("t6_addr", mem_bus.o_wire_mem_addr, 32'h0);
        check1("t6_dvi_resetn", dvi_resetn, 1'b0);
        check1("t6_busy", busy, 1'b0);
        check1("t6_done", done, 1'b0);
        check1("t6_underflow", underflow, 1'b0);
        check32("t6_uf_cnt", 32'(underflow_cnt), 32'h0);
        check32("t6_rgba", rgba, 32'h0);
        exp_addr.delete();
        exp_pix.delete();
        occ = 0;
        cons_target = 0;
        tick();
        force_ack  = 1'b1;
        force_data = 32'hCAFE_F00D;
        rstn       = 1'b1;
        tick();
        tick();
        check32("t6_late_ack_no_push", rgba, 32'h0);
        check1("t6_late_ack_busy", busy, 1'b0);
        check1("t6_late_ack_req", mem_bus.o_wire_mem_req, 1'b0);
        force_ack = 1'b0;
        tick();

        // Start on the first edge after reset release; addresses wrap at 32 bits
        rstn = 1'b0;
        tick();
        mem_en   = 1'b1;
        lat      = 0;
        cons_gap = 1;
        rstn     = 1'b1;
        start_frame(32'hFFFF_FFF8, 16'd3, 16'd1);
        wait_stream(3);
        end_frame();

        repeat (5) tick();
        check32("final_addr_queue", 32'(exp_addr.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_errors);
        $fatal(1, "watchdog");
    end
endmodule
